// File: rtl/ccg_logic_pipe.sv
// Pipelined CCGRCG-style logic block: group A is a 2-input AND, group B is a masked
// parity or AND-reduce, carried through PIPE_STAGES valid/ready stages with a hit counter.
module ccg_logic_pipe #(
  parameter int unsigned       NUM_IN      = 10,
  parameter int unsigned       NUM_OUT     = 10,
  parameter int unsigned       SPLIT       = 7,
  parameter int unsigned       A_IDX0      = 0,
  parameter int unsigned       A_IDX1      = 4,
  parameter logic [NUM_IN-1:0] B_MASK      = 10'h39E,
  parameter int unsigned       PIPE_STAGES = 2,
  parameter int unsigned       CNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NUM_IN-1:0]  x,
  input  logic               mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUM_OUT-1:0] f,
  input  logic               cnt_clr,
  output logic [CNT_W-1:0]   hit_cnt
);

  logic               a;
  logic               b;
  logic [NUM_IN-1:0]  m;
  logic [NUM_OUT-1:0] f_new;

  always_comb begin
    a     = x[A_IDX0] & x[A_IDX1];
    m     = x & B_MASK;
    // Unmasked bits are forced high so they never veto the AND-reduce.
    b     = mode ? &(m | ~B_MASK) : ^m;
    f_new = {{(NUM_OUT - SPLIT){b}}, {SPLIT{a}}};
  end

  logic [PIPE_STAGES-1:0] v_q;
  logic [PIPE_STAGES-1:0] load;
  logic [NUM_OUT-1:0]     d_q [PIPE_STAGES];

  // A stage can load unless it and every stage ahead of it are full with out_ready low.
  always_comb begin
    logic full_ahead;
    full_ahead = 1'b1;
    load       = '0;
    for (int i = PIPE_STAGES - 1; i >= 0; i--) begin
      full_ahead = full_ahead & v_q[i];
      load[i]    = out_ready | ~full_ahead;
    end
  end

  for (genvar g = 0; g < PIPE_STAGES; g++) begin : g_stage
    logic               src_v;
    logic [NUM_OUT-1:0] src_d;
    logic               stg_v_q;
    logic [NUM_OUT-1:0] stg_d_q;

    if (g == 0) begin : g_first
      assign src_v = in_valid;
      assign src_d = f_new;
    end else begin : g_rest
      assign src_v = v_q[g-1];
      assign src_d = d_q[g-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stg_v_q <= 1'b0;
        stg_d_q <= '0;
      end else if (load[g]) begin
        stg_v_q <= src_v;
        if (src_v) begin
          stg_d_q <= src_d;
        end
      end
    end

    assign v_q[g] = stg_v_q;
    assign d_q[g] = stg_d_q;
  end

  assign in_ready  = load[0];
  assign out_valid = v_q[PIPE_STAGES-1];
  assign f         = d_q[PIPE_STAGES-1];

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (out_valid && out_ready && f[NUM_OUT-1] && !(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit_cnt = cnt_q;

endmodule

// File: tb/tb_ccg_logic_pipe.sv
// Directed bench for ccg_logic_pipe: a default instance plus a CNT_W=2 instance on the
// same stimulus for the saturation case.
module tb_ccg_logic_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [9:0] x;
  logic       mode;
  logic       out_valid;
  logic       out_ready;
  logic [9:0] f;
  logic       cnt_clr;
  logic [7:0] hit_cnt;

  logic       sat_in_ready;
  logic       sat_out_valid;
  logic [9:0] sat_f;
  logic [1:0] sat_hit_cnt;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int exp_hit = 0;

  logic [9:0] exp_q [$];
  logic [9:0] exp_f;
  logic [9:0] xv;
  logic       md;

  always #5 clk = ~clk;

  ccg_logic_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .f         (f),
    .cnt_clr   (cnt_clr),
    .hit_cnt   (hit_cnt)
  );

  ccg_logic_pipe #(.CNT_W(2)) dut_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (sat_in_ready),
    .x         (x),
    .mode      (mode),
    .out_valid (sat_out_valid),
    .out_ready (out_ready),
    .f         (sat_f),
    .cnt_clr   (cnt_clr),
    .hit_cnt   (sat_hit_cnt)
  );

  function automatic logic [9:0] model(input logic [9:0] xi, input logic mi);
    logic       ra;
    logic       rb;
    logic [9:0] mm;
    ra = xi[0] & xi[4];
    mm = xi & 10'h39E;
    rb = mi ? (mm == 10'h39E) : ^mm;
    return {{3{rb}}, {7{ra}}};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_hits(input string tag);
    check({tag, "_hit"}, 32'(hit_cnt), 32'(exp_hit));
    check({tag, "_sat"}, 32'(sat_hit_cnt), (exp_hit > 3) ? 32'd3 : 32'(exp_hit));
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; x = '0; mode = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_f", 32'(f), 0);
    check("rst_hit", 32'(hit_cnt), 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_in_ready", 32'(in_ready), 1);
    check("post_rst_out_valid", 32'(out_valid), 0);

    // Basic hit beat: a=1, b=parity(bit4)=1
    x = 10'h011; mode = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("t1_valid", 32'(out_valid), 1);
    check("t1_f", 32'(f), 32'h3FF);
    tick();
    exp_hit = 1;
    check_hits("t1");
    check("t1_drained", 32'(out_valid), 0);

    // Non-hit beat followed by an AND-reduce hit beat
    x = 10'h001; mode = 1'b0; in_valid = 1'b1;
    tick();
    x = 10'h39E; mode = 1'b1;
    tick();
    in_valid = 1'b0;
    check("t2a_valid", 32'(out_valid), 1);
    check("t2a_f", 32'(f), 32'h000);
    tick();
    check("t2b_valid", 32'(out_valid), 1);
    check("t2b_f", 32'(f), 32'h380);
    check_hits("t2a");
    tick();
    exp_hit = 2;
    check_hits("t2b");

    // 20 back-to-back beats
    for (int k = 0; k < 20; k++) begin
      xv = 10'(k * 173 + 11);
      md = k[0];
      x = xv; mode = md; in_valid = 1'b1;
      exp_f = model(xv, md);
      exp_q.push_back(exp_f);
      if (exp_f[9]) exp_hit++;
      check("t3_in_ready", 32'(in_ready), 1);
      tick();
      if (k > 0) begin
        exp_f = exp_q.pop_front();
        check("t3_valid", 32'(out_valid), 1);
        check("t3_f", 32'(f), 32'(exp_f));
      end
    end
    in_valid = 1'b0;
    tick();
    exp_f = exp_q.pop_front();
    check("t3_last_valid", 32'(out_valid), 1);
    check("t3_last_f", 32'(f), 32'(exp_f));
    tick();
    check("t3_drained", 32'(out_valid), 0);
    check_hits("t3");

    // Backpressure: two accepts fill the pipe, third beat waits
    out_ready = 1'b0;
    x = 10'h011; mode = 1'b0; in_valid = 1'b1;
    #1 check("t4_rdy0", 32'(in_ready), 1);
    tick();
    x = 10'h001; mode = 1'b0;
    check("t4_rdy1", 32'(in_ready), 1);
    tick();
    x = 10'h39E; mode = 1'b1;
    check("t4_full", 32'(in_ready), 0);
    check("t4_f_b1", 32'(f), 32'h3FF);
    for (int k = 0; k < 2; k++) begin
      tick();
      check("t4_hold_valid", 32'(out_valid), 1);
      check("t4_hold_f", 32'(f), 32'h3FF);
      check("t4_hold_rdy", 32'(in_ready), 0);
    end
    check_hits("t4_stall");
    out_ready = 1'b1;
    #1 check("t4_release_rdy", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    exp_hit++;
    check("t4_b2_valid", 32'(out_valid), 1);
    check("t4_b2_f", 32'(f), 32'h000);
    tick();
    check("t4_b3_valid", 32'(out_valid), 1);
    check("t4_b3_f", 32'(f), 32'h380);
    tick();
    exp_hit++;
    check("t4_drained", 32'(out_valid), 0);
    check_hits("t4");

    // Clear, then saturate the 2-bit counter
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    exp_hit = 0;
    check_hits("t5_clr");
    x = 10'h011; mode = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    in_valid = 1'b0;
    tick(); tick();
    exp_hit = 5;
    check_hits("t5_sat");
    // Clear wins over a same-cycle hit handshake
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("t5_pending", 32'(out_valid), 1);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    exp_hit = 0;
    check_hits("t5_clr_prio");

    // One delivered hit so reset has something to clear
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    exp_hit = 1;
    check_hits("t6_pre");

    // Two beats in flight, then asynchronous reset
    in_valid = 1'b1; x = 10'h011; mode = 1'b0;
    tick();
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    check("t6_inflight", 32'(out_valid), 1);
    #1 rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(out_valid), 0);
    check("t6_rst_f", 32'(f), 0);
    check("t6_rst_hit", 32'(hit_cnt), 0);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t6_no_ghost", 32'(out_valid), 0);
      check("t6_rdy", 32'(in_ready), 1);
    end
    x = 10'h39E; mode = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("t6_new_valid", 32'(out_valid), 1);
    check("t6_new_f", 32'(f), 32'h380);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
